// File: rtl/mem_reader.sv
// Dual-stream memory reader: fetches len word pairs from base_a+i / base_b+i (each address
// wrapping at DEPTH) through a 2-entry skid FIFO onto a valid/ready output stream.
// Optional abort input: define MEM_READER_ABORT_EN.
module mem_reader #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_a,
  input  logic [ADDR_WIDTH-1:0] base_b,
  input  logic [ADDR_WIDTH:0]   len,
`ifdef MEM_READER_ABORT_EN
  input  logic                  abort,
`endif
  output logic [ADDR_WIDTH-1:0] read_addr_1,
  output logic [ADDR_WIDTH-1:0] read_addr_2,
  input  logic [DATA_WIDTH-1:0] read_data_1,
  input  logic [DATA_WIDTH-1:0] read_data_2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_a,
  output logic [DATA_WIDTH-1:0] out_b,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] AddrMax = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StFinish} state_e;

  state_e                         state_q, state_d;
  logic [ADDR_WIDTH-1:0]          addr_a_q, addr_a_d;
  logic [ADDR_WIDTH-1:0]          addr_b_q, addr_b_d;
  logic [ADDR_WIDTH:0]            rem_q, rem_d;
  logic [1:0][DATA_WIDTH-1:0]     fifo_a_q, fifo_a_d;
  logic [1:0][DATA_WIDTH-1:0]     fifo_b_q, fifo_b_d;
  logic [1:0]                     fifo_last_q, fifo_last_d;
  logic                           wr_ptr_q, wr_ptr_d;
  logic                           rd_ptr_q, rd_ptr_d;
  logic [1:0]                     count_q, count_d;

  logic issue;
  logic pop;

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    return (a == AddrMax) ? '0 : a + 1'b1;
  endfunction

  // A read is in flight only during its issue cycle (data lands at the closing edge), so
  // FIFO occupancy alone bounds outstanding data to two entries.
  assign issue = (state_q == StFetch) && (count_q != 2'd2);
  assign pop   = out_valid && out_ready;

  // Next-state logic for the job FSM, address/length counters and the output FIFO.
  always_comb begin
    state_d     = state_q;
    addr_a_d    = addr_a_q;
    addr_b_d    = addr_b_q;
    rem_d       = rem_q;
    fifo_a_d    = fifo_a_q;
    fifo_b_d    = fifo_b_q;
    fifo_last_d = fifo_last_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len == '0) begin
            state_d = StFinish;
          end else begin
            state_d  = StFetch;
            addr_a_d = base_a;
            addr_b_d = base_b;
            rem_d    = len;
          end
        end
      end
      StFetch: begin
        if (issue) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == 1) begin
            state_d = StDrain;
          end else begin
            addr_a_d = next_addr(addr_a_q);
            addr_b_d = next_addr(addr_b_q);
          end
        end
      end
      StDrain: begin
        if (pop && fifo_last_q[rd_ptr_q]) begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (issue) begin
      fifo_a_d[wr_ptr_q]    = read_data_1;
      fifo_b_d[wr_ptr_q]    = read_data_2;
      fifo_last_d[wr_ptr_q] = (rem_q == 1);
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    unique case ({issue, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

`ifdef MEM_READER_ABORT_EN
    // Abort drops the job outright: FIFO and any read landing this edge are discarded.
    if (abort && ((state_q == StFetch) || (state_q == StDrain))) begin
      state_d  = StIdle;
      rem_d    = '0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end
`endif
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      rem_q       <= '0;
      fifo_a_q    <= '0;
      fifo_b_q    <= '0;
      fifo_last_q <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      addr_a_q    <= addr_a_d;
      addr_b_q    <= addr_b_d;
      rem_q       <= rem_d;
      fifo_a_q    <= fifo_a_d;
      fifo_b_q    <= fifo_b_d;
      fifo_last_q <= fifo_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Outputs: FIFO head, status flags and the registered read addresses.
  always_comb begin
    read_addr_1 = addr_a_q;
    read_addr_2 = addr_b_q;
    out_valid   = (count_q != 2'd0);
    out_a       = fifo_a_q[rd_ptr_q];
    out_b       = fifo_b_q[rd_ptr_q];
    out_last    = fifo_last_q[rd_ptr_q] && (count_q != 2'd0);
    busy        = (state_q != StIdle);
    done        = (state_q == StFinish);
  end

endmodule

// File: doc/mem_reader.md
MEM_READER -- requirements
Module: mem_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, memory word width.
REQ-003 SHALL have parameter DEPTH, default 16, number of memory words; 2 <= DEPTH <= 2^ADDR_WIDTH.
REQ-004 SHALL have port clk  input  1  single clock; all logic is posedge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  job request; sampled only in IDLE.
REQ-007 SHALL have port base_a, base_b  input  ADDR_WIDTH each  start addresses of stream A and stream B; captured on start.
REQ-008 SHALL have port len  input  ADDR_WIDTH+1  number of word pairs to fetch; captured on start.
REQ-009 SHALL have port read_addr_1, read_addr_2  output  ADDR_WIDTH each  memory read addresses (A, B).
REQ-010 SHALL have port read_data_1, read_data_2  input  DATA_WIDTH each  memory read data, valid at the posedge after the address is driven.
REQ-011 SHALL have port out_valid / out_ready  output / input  1 each  output stream handshake.
REQ-012 SHALL have port out_a, out_b  output  DATA_WIDTH each  fetched pair.
REQ-013 SHALL have port out_last  output  1  marks the final pair of a job.
REQ-014 SHALL have port busy  output  1  high outside IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse on job completion.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, DRAIN, FINISH; IDLE->FETCH on start with len>0; IDLE->FINISH on start with len==0; FETCH->DRAIN when the last read is issued; DRAIN->FINISH when the last pair is accepted (out_valid & out_ready & out_last); FINISH->IDLE unconditionally.
REQ-017 SHALL assert done for exactly the FINISH cycle; busy SHALL be high in FETCH, DRAIN and FINISH.
REQ-018 SHALL issue one read pair per cycle in FETCH, drawn from addresses base_a+i and base_b+i, i = 0..len-1.
REQ-019 SHALL wrap each address from DEPTH-1 to 0, independently per stream.
REQ-020 SHALL capture read data one cycle after issue into a 2-entry FIFO of {a, b, last}.
REQ-021 SHALL issue a read only when FIFO occupancy plus in-flight reads is below 2; no data is ever dropped.
REQ-022 SHALL present the FIFO head on out_a/out_b/out_last with out_valid high whenever the FIFO is non-empty; a pair transfers on out_valid & out_ready.
REQ-023 SHALL keep out_a/out_b/out_last stable while out_valid is high and out_ready is low.
REQ-024 SHALL support simultaneous FIFO push and pop in one cycle.
REQ-025 SHALL sustain one pair per cycle with out_ready held high; first out_valid SHALL occur 2 cycles after the start cycle.
REQ-026 SHALL ignore start outside IDLE.
REQ-027 SHALL hold read_addr_1/read_addr_2 at their last value when no read is issued.

Reset
REQ-028 SHALL, on rst_n low, immediately force: state IDLE, FIFO empty, in-flight cleared, out_valid 0, out_last 0, out_a 0, out_b 0, busy 0, done 0, read_addr_1 0, read_addr_2 0.
REQ-029 SHALL discard any job in progress on reset, with no done pulse.

Configuration
REQ-030 SHALL, when macro MEM_READER_ABORT_EN is defined, add input port abort (1 bit): when abort is high in FETCH or DRAIN, the block SHALL flush the FIFO, discard in-flight data, and enter IDLE next cycle without a done pulse; abort is ignored in IDLE and FINISH.
REQ-031 SHALL, when MEM_READER_ABORT_EN is undefined, have no abort port and no abort logic.

Verification
REQ-032 Memory words mem[i]=i+0x100, base_a=2, base_b=9, len=3, out_ready=1 -> pairs (0x102,0x109),(0x103,0x10A),(0x104,0x10B) on consecutive cycles, out_last on the third, done one cycle later.
REQ-033 base_a=14, base_b=0, len=4, DEPTH=16 -> A addresses 14,15,0,1; B addresses 0,1,2,3.
REQ-034 len=5, out_ready low for cycles 2-6 after start -> out_valid held with first pair stable, at most 2 reads outstanding, all 5 pairs delivered in order with no loss or duplication.
REQ-035 start with len=0 -> no reads, out_valid never high, done pulse one cycle after start; start pulsed during a job -> ignored.
REQ-036 rst_n low mid-DRAIN with FIFO full -> outputs at reset values immediately, no done; new job after release runs correctly.
REQ-037 With MEM_READER_ABORT_EN, abort during FETCH of len=8 -> out_valid low next cycle, busy low, no done, no further pairs.
